// File: rtl/ap_ctrl_start_ready_sequencer.sv
// ap_ctrl start/ready/done sequencer.
// Turns the host's level-held ap_start into single-cycle start tokens for a
// relay-station pipeline. It reflects the kernel's ready/done returns back to
// the host as one-cycle pulses and bounds the number of in-flight invocations.
// After reset it stays silent for a grace period so the relay stages can flush.
module ap_ctrl_start_ready_sequencer #(
  parameter int LEVEL        = 10,
  parameter int GRACE_PERIOD = 2 * LEVEL,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             host_ap_start,
  output logic             host_ap_ready,
  output logic             host_ap_done,
  output logic             host_ap_idle,
  output logic             pp_start_token,
  input  logic             pp_ready_ret,
  input  logic             pp_done_ret,
  output logic [CNT_W-1:0] inflight_cnt,
  output logic             proto_err
);

  typedef enum logic [1:0] {
    ST_GRACE,
    ST_IDLE,
    ST_WAIT_READY
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  state_t           state;
  logic [CNT_W-1:0] grace_cnt;
  logic             grace_done;
  logic             cnt_inc;
  logic             cnt_dec;

  // Grace ends on the cycle the counter reaches GRACE_PERIOD-1.
  // A zero period ends at the first edge after reset is released.
  assign grace_done = (GRACE_PERIOD == 0) || (grace_cnt == CNT_W'(GRACE_PERIOD - 1));

  // Return pulses that affect the in-flight count. Returns that arrive
  // during grace are stale pipeline contents, so they are not counted.
  assign cnt_inc = (state == ST_WAIT_READY) && pp_ready_ret;
  assign cnt_dec = (state != ST_GRACE) && pp_done_ret;

  // Handshake FSM, in-flight counter and all registered outputs.
  // NOTE: sequential state uses non-blocking (<=) assignments only. Every
  // register then samples its pre-edge value, whatever the statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: every register here is reset asynchronously. A reset in the
      // middle of a transaction must silence all outputs immediately.
      state          <= ST_GRACE;
      grace_cnt      <= '0;
      inflight_cnt   <= '0;
      proto_err      <= 1'b0;
      pp_start_token <= 1'b0;
      host_ap_ready  <= 1'b0;
      host_ap_done   <= 1'b0;
      host_ap_idle   <= 1'b0;
    end else begin
      pp_start_token <= 1'b0;
      host_ap_ready  <= 1'b0;
      host_ap_done   <= 1'b0;
      host_ap_idle   <= (state == ST_IDLE) && (inflight_cnt == '0) && !host_ap_start;

      case (state)
        ST_GRACE: begin
          grace_cnt <= grace_cnt + 1'b1;
          if (grace_done) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (pp_ready_ret) proto_err <= 1'b1;
          if (host_ap_start && (inflight_cnt < MAX_CNT)) begin
            pp_start_token <= 1'b1;
            state          <= ST_WAIT_READY;
          end
        end
        ST_WAIT_READY: begin
          if (pp_ready_ret) begin
            host_ap_ready <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_GRACE;
      endcase

      // A done with nothing in flight and no ready beside it is a protocol
      // error. It produces no host pulse.
      if (cnt_dec) begin
        if (!cnt_inc && (inflight_cnt == '0)) proto_err    <= 1'b1;
        else                                  host_ap_done <= 1'b1;
      end

      // A ready and a done in the same cycle cancel out. The count
      // saturates at both ends.
      if (cnt_inc && !cnt_dec && (inflight_cnt < MAX_CNT))
        inflight_cnt <= inflight_cnt + 1'b1;
      else if (cnt_dec && !cnt_inc && (inflight_cnt != '0))
        inflight_cnt <= inflight_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_ap_ctrl_start_ready_sequencer.sv
// Directed testbench for ap_ctrl_start_ready_sequencer (LEVEL=10, GRACE_PERIOD=20).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_ap_ctrl_start_ready_sequencer;

  localparam int GP    = 20;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             host_ap_start;
  logic             host_ap_ready;
  logic             host_ap_done;
  logic             host_ap_idle;
  logic             pp_start_token;
  logic             pp_ready_ret;
  logic             pp_done_ret;
  logic [CNT_W-1:0] inflight_cnt;
  logic             proto_err;

  int checks   = 0;
  int failures = 0;
  int tok_cnt  = 0;
  int rdy_cnt  = 0;
  int done_cnt = 0;

  ap_ctrl_start_ready_sequencer #(
    .LEVEL(10), .GRACE_PERIOD(GP), .MAX_INFLIGHT(4), .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .host_ap_start (host_ap_start),
    .host_ap_ready (host_ap_ready),
    .host_ap_done  (host_ap_done),
    .host_ap_idle  (host_ap_idle),
    .pp_start_token(pp_start_token),
    .pp_ready_ret  (pp_ready_ret),
    .pp_done_ret   (pp_done_ret),
    .inflight_cnt  (inflight_cnt),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  // Independent pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (pp_start_token) tok_cnt++;
    if (host_ap_ready)  rdy_cnt++;
    if (host_ap_done)   done_cnt++;
  end

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ready();
    pp_ready_ret = 1'b1;
    tick();
    pp_ready_ret = 1'b0;
  endtask

  task automatic pulse_done();
    pp_done_ret = 1'b1;
    tick();
    pp_done_ret = 1'b0;
  endtask

  // Waits a bounded number of cycles for a start token.
  task automatic wait_token(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pp_start_token) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, int'(seen), 1);
  endtask

  // Call right after reset release with host_ap_start high. Edges 1..GP
  // must stay silent and the token must leave on edge GP+1.
  task automatic grace_check(input string tag);
    int toks = 0;
    int idles = 0;
    for (int i = 0; i < GP; i++) begin
      tick();
      if (pp_start_token) toks++;
      if (host_ap_idle)   idles++;
    end
    check({tag, "_no_token"}, toks, 0);
    check({tag, "_idle_low"}, idles, 0);
    tick();
    check({tag, "_token"}, int'(pp_start_token), 1);
  endtask

  initial begin
    int base_tok;
    int base_rdy;
    reset         = 1'b0;
    host_ap_start = 1'b1;
    pp_ready_ret  = 1'b0;
    pp_done_ret   = 1'b0;
    repeat (3) tick();
    check("rst_token", int'(pp_start_token), 0);
    check("rst_ready", int'(host_ap_ready), 0);
    check("rst_idle",  int'(host_ap_idle), 0);
    check("rst_cnt",   int'(inflight_cnt), 0);
    check("rst_err",   int'(proto_err), 0);

    // Grace period with start held high.
    reset = 1'b1;
    grace_check("grace1");
    tick();
    check("token_one_cycle", int'(pp_start_token), 0);

    // Single invocation: ready 20 cycles after the token, done at +50.
    repeat (18) tick();
    pulse_ready();
    host_ap_start = 1'b0;
    check("single_ready", int'(host_ap_ready), 1);
    check("single_cnt1",  int'(inflight_cnt), 1);
    tick();
    check("single_ready_width", int'(host_ap_ready), 0);
    check("single_no_token",    int'(pp_start_token), 0);
    repeat (28) tick();
    pulse_done();
    check("single_done", int'(host_ap_done), 1);
    check("single_cnt0", int'(inflight_cnt), 0);
    tick();
    check("single_done_width", int'(host_ap_done), 0);
    check("single_idle",       int'(host_ap_idle), 1);

    // Back-to-back invocations up to the in-flight limit.
    base_tok = tok_cnt;
    base_rdy = rdy_cnt;
    host_ap_start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_token($sformatf("b2b_token%0d", k));
      repeat (19) tick();
      pulse_ready();
      check($sformatf("b2b_ready%0d", k), int'(host_ap_ready), 1);
    end
    repeat (10) tick();
    check("b2b_tokens", tok_cnt - base_tok, 4);
    check("b2b_readys", rdy_cnt - base_rdy, 4);
    check("b2b_cnt4",   int'(inflight_cnt), 4);
    pulse_done();
    check("b2b_done",       int'(host_ap_done), 1);
    check("b2b_cnt3",       int'(inflight_cnt), 3);
    check("b2b_no_tok_yet", int'(pp_start_token), 0);
    tick();
    check("b2b_5th_token",  int'(pp_start_token), 1);

    // Simultaneous ready and done with two in flight.
    pulse_done();
    check("sim_pre_cnt2", int'(inflight_cnt), 2);
    pp_ready_ret = 1'b1;
    pp_done_ret  = 1'b1;
    tick();
    pp_ready_ret  = 1'b0;
    pp_done_ret   = 1'b0;
    host_ap_start = 1'b0;
    check("sim_ready", int'(host_ap_ready), 1);
    check("sim_done",  int'(host_ap_done), 1);
    check("sim_cnt2",  int'(inflight_cnt), 2);

    // Drain, then a done with nothing in flight.
    pulse_done();
    pulse_done();
    check("drain_cnt0", int'(inflight_cnt), 0);
    check("err_clear",  int'(proto_err), 0);
    pulse_done();
    check("err_done_set",     int'(proto_err), 1);
    check("err_done_no_done", int'(host_ap_done), 0);
    check("err_done_cnt0",    int'(inflight_cnt), 0);
    repeat (3) tick();
    check("err_sticky", int'(proto_err), 1);

    // Build three in flight, then reset in the middle of WAIT_READY.
    host_ap_start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_token($sformatf("mid_token%0d", k));
      pulse_ready();
    end
    wait_token("mid_token3");
    check("mid_cnt3", int'(inflight_cnt), 3);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_token", int'(pp_start_token), 0);
    check("mid_rst_cnt",   int'(inflight_cnt), 0);
    check("mid_rst_err",   int'(proto_err), 0);
    tick();
    reset = 1'b1;
    grace_check("grace2");

    // A ready that arrives in IDLE is a protocol error.
    pulse_ready();
    host_ap_start = 1'b0;
    tick();
    check("idle_err_pre", int'(proto_err), 0);
    pulse_ready();
    check("idle_err_set",   int'(proto_err), 1);
    check("idle_err_no_rdy", int'(host_ap_ready), 0);
    check("idle_err_cnt1",  int'(inflight_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
